ascon_permutation_unrolled: RTL and testbench

- Parametrised successor of the iterative ASCON permutation: applies a run-time selectable number of ASCON rounds (1..12) to a 320-bit state.
- Evaluates UNROLL rounds per clock through a chain of round stages. Stages past the final round are bypassed, so any round count works with any UNROLL.
- Owns its round counter and a valid/ready handshake on both sides. Sits between the ASCON control FSM and the data-path XOR/padding logic, and replaces the externally sequenced mux/register/round_i arrangement.

---
 rtl/ascon_pack.sv | 35 +++
 rtl/ascon_round.sv | 48 ++++
 rtl/ascon_permutation_unrolled.sv | 104 ++++++++++
 tb/tb_ascon_permutation_unrolled.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the unrolled ASCON permutation.
package ascon_pack;

  // Five 64-bit words; index 0 is x0.
  typedef logic [4:0][63:0] type_state;

  // Round constants for p^12, indexed by round number.
  localparam logic [0:11][7:0] ROUND_CST = {
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // 5-bit S-box; input/output bit 4 is x0, bit 0 is x4.
  localparam logic [0:31][4:0] SBOX_TBL = {
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  // Linear-layer right-rotation amounts per word.
  localparam logic [0:4][5:0] ROT_A = {6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
  localparam logic [0:4][5:0] ROT_B = {6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  function automatic logic [4:0] sbox(input logic [4:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round; passes the state through when en_i is low.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  input  logic       en_i,
  output type_state  state_o
);

  type_state  cst_s;
  type_state  sbox_s;
  type_state  lin_s;
  logic [7:0] cst;

  // Constant addition into the low byte of x2.
  always_comb begin
    cst   = (round_i < 4'd12) ? ROUND_CST[round_i] : '0;
    cst_s = state_i;
    cst_s[2][7:0] = state_i[2][7:0] ^ cst;
  end

  // Column-wise substitution layer.
  always_comb begin
    logic [4:0] col;
    col    = '0;
    sbox_s = '0;
    for (int unsigned b = 0; b < 64; b++) begin
      col = sbox({cst_s[0][b], cst_s[1][b], cst_s[2][b], cst_s[3][b], cst_s[4][b]});
      sbox_s[0][b] = col[4];
      sbox_s[1][b] = col[3];
      sbox_s[2][b] = col[2];
      sbox_s[3][b] = col[1];
      sbox_s[4][b] = col[0];
    end
  end

  // Linear diffusion layer, one sigma per word.
  always_comb begin
    lin_s = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      lin_s[i] = sbox_s[i] ^ rotr(sbox_s[i], ROT_A[i]) ^ rotr(sbox_s[i], ROT_B[i]);
    end
  end

  assign state_o = en_i ? lin_s : state_i;

endmodule

// File: rtl/ascon_permutation_unrolled.sv
// ASCON permutation applying UNROLL rounds per clock with valid/ready on both sides.
module ascon_permutation_unrolled
  import ascon_pack::*;
#(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  type_state  state_i,
  input  logic [3:0] rounds_i,
  output logic       valid_o,
  input  logic       ready_i,
  output type_state  state_o,
  output logic       busy_o
);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_permutation_unrolled: UNROLL must be in 1..4");
  end

  localparam logic [4:0] LAST = 5'(MAX_ROUNDS);
  localparam logic [4:0] STEP = 5'(UNROLL);

  fsm_e       fsm_q, fsm_d;
  type_state  st_q, st_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0] rounds_cl;
  logic       accept;
  type_state  chain [UNROLL+1];

  assign rounds_cl = (rounds_i > LAST[3:0]) ? LAST[3:0] : rounds_i;
  assign accept    = valid_i & ready_o;
  assign chain[0]  = st_q;

  // Stages whose round index runs past the schedule end act as wires, so the
  // round count need not be a multiple of UNROLL.
  for (genvar j = 0; j < UNROLL; j++) begin : g_stage
    logic [4:0] ridx;
    assign ridx = idx_q + 5'(j);
    ascon_round u_round (
      .state_i (chain[j]),
      .round_i (ridx[3:0]),
      .en_i    (ridx < LAST),
      .state_o (chain[j+1])
    );
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (resetb_i) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // FSM next-state: a DONE job handed off with a new accept reloads directly.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (accept) fsm_d = (rounds_cl == '0) ? DONE : RUN;
      RUN:     if (idx_q + STEP >= LAST) fsm_d = DONE;
      DONE: begin
        if (accept)       fsm_d = (rounds_cl == '0) ? DONE : RUN;
        else if (ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready_o = (fsm_q == IDLE) || ((fsm_q == DONE) && ready_i);
    valid_o = (fsm_q == DONE);
    busy_o  = (fsm_q == RUN);
  end

  // Datapath next-state: load on accept, advance the round chain in RUN.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    if (accept) begin
      st_d  = state_i;
      idx_d = LAST - {1'b0, rounds_cl};
    end else if (fsm_q == RUN) begin
      st_d  = chain[UNROLL];
      idx_d = idx_q + STEP;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      st_q  <= '0;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  assign state_o = st_q;

endmodule

// File: tb/tb_ascon_permutation_unrolled.sv
// Directed bench for ascon_permutation_unrolled, UNROLL=1 and UNROLL=4 side by side.
module tb_ascon_permutation_unrolled;

  typedef logic [4:0][63:0] st_t;

  logic       clk = 1'b0;
  logic       resetb_i;
  logic       valid_i;
  logic       ready_i;
  st_t        state_i;
  logic [3:0] rounds_i;

  logic ready1, valid1, busy1, ready4, valid4, busy4;
  st_t  st1, st4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ascon_permutation_unrolled #(.UNROLL(1), .MAX_ROUNDS(12)) u1 (
    .clock_i(clk), .resetb_i(resetb_i), .valid_i(valid_i), .ready_o(ready1),
    .state_i(state_i), .rounds_i(rounds_i), .valid_o(valid1), .ready_i(ready_i),
    .state_o(st1), .busy_o(busy1)
  );

  ascon_permutation_unrolled #(.UNROLL(4), .MAX_ROUNDS(12)) u4 (
    .clock_i(clk), .resetb_i(resetb_i), .valid_i(valid_i), .ready_o(ready4),
    .state_i(state_i), .rounds_i(rounds_i), .valid_o(valid4), .ready_i(ready_i),
    .state_o(st4), .busy_o(busy4)
  );

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference round in the bitsliced formulation of the ASCON C code.
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t ref_round(input st_t s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'd0, 4'(15 - r), 4'(r)};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic st_t ref_perm(input st_t s, input int rounds);
    st_t t = s;
    int  rc = (rounds > 12) ? 12 : rounds;
    for (int r = 12 - rc; r < 12; r++) t = ref_round(t, r);
    return t;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  // Present a job while both instances are ready; returns #1 after the accept edge.
  task automatic start_job(input st_t s, input logic [3:0] r, input string tag);
    state_i  = s;
    rounds_i = r;
    valid_i  = 1'b1;
    #1;
    check({tag, "_acc_rdy1"}, 320'(ready1), 320'(1'b1));
    check({tag, "_acc_rdy4"}, 320'(ready4), 320'(1'b1));
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Follow both instances until valid_o; checks latency, busy length, ready in RUN, result.
  task automatic wait_done(input st_t e1, input st_t e4, input int n1, input int n4,
                           input string tag, input bit toggle);
    int c1 = -1;
    int c4 = -1;
    int b1 = 0;
    int b4 = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (toggle && cyc == 0) begin
        valid_i = 1'b1;
        state_i = ~state_i;
      end
      if (toggle && cyc == 1) valid_i = 1'b0;
      #0;
      if (c1 < 0) begin
        if (valid1) begin
          c1 = cyc;
          check({tag, "_st1"}, st1, e1);
        end else if (busy1) begin
          b1++;
          check({tag, "_runrdy1"}, 320'(ready1), 320'(1'b0));
        end
      end
      if (c4 < 0) begin
        if (valid4) begin
          c4 = cyc;
          check({tag, "_st4"}, st4, e4);
        end else if (busy4) begin
          b4++;
          check({tag, "_runrdy4"}, 320'(ready4), 320'(1'b0));
        end
      end
      if (c1 >= 0 && c4 >= 0) break;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check({tag, "_lat1"},  320'(c1), 320'(n1));
    check({tag, "_lat4"},  320'(c4), 320'(n4));
    check({tag, "_busy1"}, 320'(b1), 320'(n1));
    check({tag, "_busy4"}, 320'(b4), 320'(n4));
  endtask

  initial begin
    st_t zero, hand, pat, s, s2;
    zero = '0;
    // Round 11 applied to the all-zero state, worked out by hand.
    hand[0] = 64'h000964B00000004B;
    hand[1] = 64'h0000000096000213;
    hand[2] = 64'h53FFFFFFFFFFFF90;
    hand[3] = 64'h12E580000000004B;
    hand[4] = 64'h0000000000000000;
    for (int i = 0; i < 5; i++) pat[i] = 64'h0123456789ABCDEF;

    resetb_i = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    state_i  = '0;
    rounds_i = '0;
    repeat (2) @(posedge clk);
    #1;
    resetb_i = 1'b0;
    check("rst_valid1", 320'(valid1), 320'(1'b0));
    check("rst_busy1",  320'(busy1),  320'(1'b0));
    check("rst_ready1", 320'(ready1), 320'(1'b1));
    check("rst_st1",    st1, zero);
    check("rst_valid4", 320'(valid4), 320'(1'b0));
    check("rst_st4",    st4, zero);

    // Full p12 on zero state.
    start_job(zero, 4'd12, "p12z");
    wait_done(ref_perm(zero, 12), ref_perm(zero, 12), 12, 3, "p12z", 1'b0);

    // Single final round: hand-computed, exercises bypass of stages 1..3.
    start_job(zero, 4'd1, "r1");
    wait_done(hand, hand, 1, 1, "r1", 1'b0);

    // Six rounds on random state: second UNROLL=4 cycle bypasses two stages.
    s = rand_state();
    start_job(s, 4'd6, "r6");
    wait_done(ref_perm(s, 6), ref_perm(s, 6), 6, 2, "r6", 1'b0);

    // Zero rounds: pass-through on the cycle after accept.
    start_job(pat, 4'd0, "r0");
    wait_done(pat, pat, 0, 0, "r0", 1'b0);

    // Rounds 15 clamp to 12.
    s = rand_state();
    start_job(s, 4'd15, "r15");
    wait_done(ref_perm(s, 12), ref_perm(s, 12), 12, 3, "r15", 1'b0);

    // Backpressure in DONE, then a back-to-back job on the handoff edge.
    @(posedge clk); #1;
    s  = rand_state();
    s2 = rand_state();
    ready_i = 1'b0;
    start_job(s, 4'd12, "bp");
    wait_done(ref_perm(s, 12), ref_perm(s, 12), 12, 3, "bp", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid1", 320'(valid1), 320'(1'b1));
      check("bp_hold_st1",    st1, ref_perm(s, 12));
      check("bp_hold_ready1", 320'(ready1), 320'(1'b0));
      check("bp_hold_valid4", 320'(valid4), 320'(1'b1));
      check("bp_hold_st4",    st4, ref_perm(s, 12));
    end
    ready_i = 1'b1;
    start_job(s2, 4'd5, "b2b");
    check("b2b_drop_valid1", 320'(valid1), 320'(1'b0));
    wait_done(ref_perm(s2, 5), ref_perm(s2, 5), 5, 2, "b2b", 1'b0);

    // Reset in the third RUN cycle discards the job.
    @(posedge clk); #1;
    s = rand_state();
    start_job(s, 4'd12, "rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetb_i = 1'b1;
    @(posedge clk); #1;
    resetb_i = 1'b0;
    check("mrst_valid1", 320'(valid1), 320'(1'b0));
    check("mrst_busy1",  320'(busy1),  320'(1'b0));
    check("mrst_ready1", 320'(ready1), 320'(1'b1));
    check("mrst_st1",    st1, zero);
    check("mrst_valid4", 320'(valid4), 320'(1'b0));
    check("mrst_busy4",  320'(busy4),  320'(1'b0));
    check("mrst_st4",    st4, zero);

    s = rand_state();
    start_job(s, 4'd8, "post");
    wait_done(ref_perm(s, 8), ref_perm(s, 8), 8, 2, "post", 1'b0);

    // valid_i toggled with a different state_i while running.
    @(posedge clk); #1;
    s = rand_state();
    start_job(s, 4'd12, "tog");
    wait_done(ref_perm(s, 12), ref_perm(s, 12), 12, 3, "tog", 1'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
